// File: rtl/vend_controller.sv
// ---------------------------------------------------------------------------
// vend_controller
// Sequencing FSM for the vending machine. It accumulates coin credit, looks up
// the selected item's price through an external combinational table, checks
// the credit against that price, then dispenses the item and returns change.
// All pulse and data outputs are registered.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   coin_valid      one-cycle pulse: coin inserted, coin_type 0=5c 1=10c 2=25c 3=100c
//   item_sel, buy   purchase request (item_sel sampled with buy)
//   cancel          one-cycle pulse: refund all credit
//   cost_sel        item index driven to the price table
//   cost_in         price in cents returned by the table in the same cycle
//   credit          current credit in cents
//   coin_reject     one-cycle pulse: coin refused
//   insufficient    one-cycle pulse: buy refused because credit < price
//   dispense        one-cycle pulse with dispense_item: release item
//   change_valid    one-cycle pulse with change_amt: return change/refund
//   busy            high while a purchase or refund is in progress
// ---------------------------------------------------------------------------
module vend_controller #(
    parameter int CREDIT_W    = 10,
    parameter int MAX_CREDIT  = 500,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                coin_valid,
    input  logic [1:0]          coin_type,
    input  logic [2:0]          item_sel,
    input  logic                buy,
    input  logic                cancel,
    output logic [2:0]          cost_sel,
    input  logic [8:0]          cost_in,
    output logic [CREDIT_W-1:0] credit,
    output logic                coin_reject,
    output logic                insufficient,
    output logic                dispense,
    output logic [2:0]          dispense_item,
    output logic                change_valid,
    output logic [CREDIT_W-1:0] change_amt,
    output logic                busy
);

    localparam int IDLE_W = $clog2(TIMEOUT_CYC);
    localparam logic [IDLE_W-1:0]   IDLE_LAST = IDLE_W'(TIMEOUT_CYC - 1);
    localparam logic [CREDIT_W:0]   MAX_SUM   = (CREDIT_W + 1)'(MAX_CREDIT);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CREDIT   = 3'd1,
        LOOKUP   = 3'd2,
        CHECK    = 3'd3,
        DISPENSE = 3'd4,
        CHANGE   = 3'd5
    } state_t;

    state_t               state_r, state_s;
    logic [CREDIT_W-1:0]  credit_r, credit_s;
    logic [2:0]           sel_r, sel_s;
    logic [8:0]           cost_r, cost_s;
    logic [IDLE_W-1:0]    idle_cnt_r, idle_cnt_s;
    logic                 coin_reject_r, coin_reject_s;
    logic                 insufficient_r, insufficient_s;
    logic                 dispense_r, dispense_s;
    logic [2:0]           dispense_item_r, dispense_item_s;
    logic                 change_valid_r, change_valid_s;
    logic [CREDIT_W-1:0]  change_amt_r, change_amt_s;
    logic                 busy_r, busy_s;
    logic [CREDIT_W:0]    coin_sum_s;
    logic [CREDIT_W-1:0]  cost_ext_s;

    // Face value of a coin in cents.
    function automatic logic [CREDIT_W-1:0] coin_value(input logic [1:0] kind);
        case (kind)
            2'd0:    return CREDIT_W'(5);
            2'd1:    return CREDIT_W'(10);
            2'd2:    return CREDIT_W'(25);
            2'd3:    return CREDIT_W'(100);
            default: return '0;
        endcase
    endfunction

    // One extra bit so the ceiling compare cannot wrap.
    assign coin_sum_s = {1'b0, credit_r} + {1'b0, coin_value(coin_type)};
    assign cost_ext_s = {{(CREDIT_W - 9){1'b0}}, cost_r};

    // Next-state and next-output logic; every output is computed here and registered below.
    always_comb begin
        state_s         = state_r;
        credit_s        = credit_r;
        sel_s           = sel_r;
        cost_s          = cost_r;
        idle_cnt_s      = '0;
        coin_reject_s   = 1'b0;
        insufficient_s  = 1'b0;
        dispense_s      = 1'b0;
        dispense_item_s = 3'd0;
        change_valid_s  = 1'b0;
        change_amt_s    = '0;

        case (state_r)
            IDLE, CREDIT: begin
                // Priority cancel > buy > coin; a coin losing to cancel/buy is refused.
                if (cancel && (state_r == CREDIT)) begin
                    state_s        = CHANGE;
                    change_valid_s = 1'b1;
                    change_amt_s   = credit_r;
                    credit_s       = '0;
                    coin_reject_s  = coin_valid;
                end else if (buy) begin
                    sel_s         = item_sel;
                    state_s       = LOOKUP;
                    coin_reject_s = coin_valid;
                end else if (coin_valid) begin
                    if (coin_sum_s <= MAX_SUM) begin
                        credit_s = coin_sum_s[CREDIT_W-1:0];
                        state_s  = CREDIT;
                    end else begin
                        coin_reject_s = 1'b1;
                    end
                end else if (state_r == CREDIT) begin
                    // Quiet cycle holding credit: count towards the auto refund.
                    if (idle_cnt_r == IDLE_LAST) begin
                        state_s        = CHANGE;
                        change_valid_s = 1'b1;
                        change_amt_s   = credit_r;
                        credit_s       = '0;
                    end else begin
                        idle_cnt_s = idle_cnt_r + IDLE_W'(1);
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            LOOKUP: begin
                cost_s        = cost_in;
                state_s       = CHECK;
                coin_reject_s = coin_valid;
            end
            CHECK: begin
                coin_reject_s = coin_valid;
                if (credit_r >= cost_ext_s) begin
                    credit_s        = credit_r - cost_ext_s;
                    state_s         = DISPENSE;
                    dispense_s      = 1'b1;
                    dispense_item_s = sel_r;
                end else begin
                    insufficient_s = 1'b1;
                    state_s        = (credit_r == '0) ? IDLE : CREDIT;
                end
            end
            DISPENSE: begin
                coin_reject_s = coin_valid;
                if (credit_r != '0) begin
                    state_s        = CHANGE;
                    change_valid_s = 1'b1;
                    change_amt_s   = credit_r;
                    credit_s       = '0;
                end else begin
                    state_s = IDLE;
                end
            end
            CHANGE: begin
                coin_reject_s = coin_valid;
                state_s       = IDLE;
            end
            default: begin
                state_s  = IDLE;
                credit_s = '0;
            end
        endcase

        busy_s = (state_s == LOOKUP) || (state_s == CHECK) ||
                 (state_s == DISPENSE) || (state_s == CHANGE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r         <= IDLE;
            credit_r        <= '0;
            sel_r           <= 3'd0;
            cost_r          <= 9'd0;
            idle_cnt_r      <= '0;
            coin_reject_r   <= 1'b0;
            insufficient_r  <= 1'b0;
            dispense_r      <= 1'b0;
            dispense_item_r <= 3'd0;
            change_valid_r  <= 1'b0;
            change_amt_r    <= '0;
            busy_r          <= 1'b0;
        end else begin
            state_r         <= state_s;
            credit_r        <= credit_s;
            sel_r           <= sel_s;
            cost_r          <= cost_s;
            idle_cnt_r      <= idle_cnt_s;
            coin_reject_r   <= coin_reject_s;
            insufficient_r  <= insufficient_s;
            dispense_r      <= dispense_s;
            dispense_item_r <= dispense_item_s;
            change_valid_r  <= change_valid_s;
            change_amt_r    <= change_amt_s;
            busy_r          <= busy_s;
        end
    end

    assign cost_sel      = sel_r;
    assign credit        = credit_r;
    assign coin_reject   = coin_reject_r;
    assign insufficient  = insufficient_r;
    assign dispense      = dispense_r;
    assign dispense_item = dispense_item_r;
    assign change_valid  = change_valid_r;
    assign change_amt    = change_amt_r;
    assign busy          = busy_r;

endmodule

// File: tb/tb_vend_controller.sv
// ---------------------------------------------------------------------------
// tb_vend_controller
// Self-checking bench for vend_controller: directed scenarios followed by a
// randomized sequence of coin / buy / cancel transactions checked against a
// transaction-level credit model. Inputs change and outputs are sampled on
// the falling clock edge.
// ---------------------------------------------------------------------------
module tb_vend_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       coin_valid;
    logic [1:0] coin_type;
    logic [2:0] item_sel;
    logic       buy;
    logic       cancel;
    logic [2:0] cost_sel;
    logic [8:0] cost_in;
    logic [9:0] credit;
    logic       coin_reject;
    logic       insufficient;
    logic       dispense;
    logic [2:0] dispense_item;
    logic       change_valid;
    logic [9:0] change_amt;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;
    int m_credit = 0;

    int obs_reject, obs_disp, obs_change, obs_insuf;
    int reject_at, disp_at, change_at, insuf_at;
    int obs_item, obs_amt;

    vend_controller dut (
        .clk(clk), .rst_n(rst_n), .coin_valid(coin_valid), .coin_type(coin_type),
        .item_sel(item_sel), .buy(buy), .cancel(cancel), .cost_sel(cost_sel),
        .cost_in(cost_in), .credit(credit), .coin_reject(coin_reject),
        .insufficient(insufficient), .dispense(dispense), .dispense_item(dispense_item),
        .change_valid(change_valid), .change_amt(change_amt), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic int price_of(input int item);
        case (item)
            0: return 125;
            1: return 50;
            2: return 85;
            3: return 150;
            4: return 225;
            5: return 65;
            6: return 300;
            default: return 10;
        endcase
    endfunction

    function automatic int cents_of(input int kind);
        case (kind)
            0: return 5;
            1: return 10;
            2: return 25;
            default: return 100;
        endcase
    endfunction

    // Price table seen by the controller.
    always_comb cost_in = 9'(price_of(int'(cost_sel)));

    task automatic drive_coin(input int kind);
        coin_valid = 1'b1;
        coin_type  = 2'(kind);
        @(negedge clk);
        coin_valid = 1'b0;
    endtask

    task automatic drive_buy(input int item);
        buy      = 1'b1;
        item_sel = 3'(item);
        @(negedge clk);
        buy = 1'b0;
    endtask

    task automatic drive_cancel();
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
    endtask

    // Record output pulses over ncyc falling edges, starting with the current one.
    task automatic observe(input int ncyc);
        obs_reject = 0; obs_disp = 0; obs_change = 0; obs_insuf = 0;
        reject_at = -1; disp_at = -1; change_at = -1; insuf_at = -1;
        obs_item = -1; obs_amt = -1;
        for (int i = 0; i < ncyc; i++) begin
            if (coin_reject === 1'b1) begin
                obs_reject++;
                if (reject_at < 0) reject_at = i;
            end
            if (dispense === 1'b1) begin
                obs_disp++; disp_at = i; obs_item = int'(dispense_item);
            end
            if (change_valid === 1'b1) begin
                obs_change++; change_at = i; obs_amt = int'(change_amt);
            end
            if (insufficient === 1'b1) begin
                obs_insuf++; insuf_at = i;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; coin_valid = 1'b0; coin_type = 2'd0; item_sel = 3'd0;
        buy = 1'b0; cancel = 1'b0;
        #12;
        n_checks++;
        if ({credit, coin_reject, insufficient, dispense, dispense_item,
             change_valid, change_amt, busy, cost_sel} !== 33'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h required 0", {credit, coin_reject,
                     insufficient, dispense, dispense_item, change_valid, change_amt, busy, cost_sel});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        m_credit = 0;
    endtask

    task automatic test_exact_buy();
        drive_coin(3); drive_coin(2);
        drive_buy(0);
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL exact_busy: got %b required 1", busy); end
        observe(6);
        n_checks++;
        if (disp_at !== 2 || obs_item !== 0) begin
            n_fail++; $display("FAIL exact_dispense: at %0d item %0d required at 2 item 0", disp_at, obs_item);
        end
        n_checks++;
        if (obs_change !== 0) begin n_fail++; $display("FAIL exact_no_change: got %0d pulses required 0", obs_change); end
        n_checks++;
        if (credit !== 10'd0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL exact_final: credit %0d busy %b required 0 0", credit, busy);
        end
    endtask

    task automatic test_buy_with_change();
        drive_coin(3); drive_coin(3);
        drive_buy(2);
        observe(6);
        n_checks++;
        if (disp_at !== 2 || obs_item !== 2) begin
            n_fail++; $display("FAIL change_dispense: at %0d item %0d required at 2 item 2", disp_at, obs_item);
        end
        n_checks++;
        if (change_at !== 3 || obs_amt !== 115) begin
            n_fail++; $display("FAIL change_amt: at %0d amt %0d required at 3 amt 115", change_at, obs_amt);
        end
        n_checks++;
        if (credit !== 10'd0) begin n_fail++; $display("FAIL change_credit: got %0d required 0", credit); end
    endtask

    task automatic test_insufficient();
        drive_coin(2); drive_coin(2);
        drive_buy(4);
        observe(6);
        n_checks++;
        if (insuf_at !== 2 || obs_insuf !== 1 || obs_disp !== 0) begin
            n_fail++; $display("FAIL insufficient_pulse: at %0d count %0d disp %0d required at 2 count 1 disp 0",
                               insuf_at, obs_insuf, obs_disp);
        end
        n_checks++;
        if (credit !== 10'd50 || busy !== 1'b0) begin
            n_fail++; $display("FAIL insufficient_credit: credit %0d busy %b required 50 0", credit, busy);
        end
        drive_cancel();
        observe(3);
        n_checks++;
        if (change_at !== 0 || obs_amt !== 50 || credit !== 10'd0) begin
            n_fail++; $display("FAIL cancel_refund: at %0d amt %0d credit %0d required at 0 amt 50 credit 0",
                               change_at, obs_amt, credit);
        end
    endtask

    task automatic test_coin_reject();
        for (int i = 0; i < 4; i++) drive_coin(3);
        drive_coin(2); drive_coin(2);
        drive_coin(3);
        observe(2);
        n_checks++;
        if (reject_at !== 0 || credit !== 10'd450) begin
            n_fail++; $display("FAIL ceiling_reject: at %0d credit %0d required at 0 credit 450", reject_at, credit);
        end
        // Coin arrives while the price lookup is in progress.
        buy = 1'b1; item_sel = 3'd3;
        @(negedge clk);
        buy = 1'b0; coin_valid = 1'b1; coin_type = 2'd0;
        @(negedge clk);
        coin_valid = 1'b0;
        n_checks++;
        if (coin_reject !== 1'b1 || credit !== 10'd450) begin
            n_fail++; $display("FAIL lookup_reject: reject %b credit %0d required 1 450", coin_reject, credit);
        end
        observe(5);
        n_checks++;
        if (obs_disp !== 1 || obs_item !== 3 || obs_amt !== 300) begin
            n_fail++; $display("FAIL lookup_purchase: disp %0d item %0d amt %0d required 1 3 300",
                               obs_disp, obs_item, obs_amt);
        end
    endtask

    task automatic test_simultaneous();
        drive_coin(2); drive_coin(2); drive_coin(1);
        cancel = 1'b1; buy = 1'b1; item_sel = 3'd1; coin_valid = 1'b1; coin_type = 2'd1;
        @(negedge clk);
        cancel = 1'b0; buy = 1'b0; coin_valid = 1'b0;
        observe(5);
        n_checks++;
        if (change_at !== 0 || obs_amt !== 60 || reject_at !== 0) begin
            n_fail++; $display("FAIL simultaneous_refund: change at %0d amt %0d reject at %0d required 0 60 0",
                               change_at, obs_amt, reject_at);
        end
        n_checks++;
        if (obs_disp !== 0 || credit !== 10'd0) begin
            n_fail++; $display("FAIL simultaneous_nodispense: disp %0d credit %0d required 0 0", obs_disp, credit);
        end
    endtask

    task automatic test_timeout();
        drive_coin(1);
        observe(1005);
        n_checks++;
        if (obs_change !== 1 || change_at !== 1000 || obs_amt !== 10) begin
            n_fail++; $display("FAIL timeout_refund: count %0d at %0d amt %0d required 1 1000 10",
                               obs_change, change_at, obs_amt);
        end
    endtask

    task automatic test_reset_mid();
        drive_coin(3);
        drive_buy(1);
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (dispense !== 1'b1) begin n_fail++; $display("FAIL midreset_reach: dispense %b required 1", dispense); end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({credit, dispense, dispense_item, change_valid, change_amt, busy, insufficient, coin_reject} !== 30'd0) begin
            n_fail++; $display("FAIL midreset_outputs: got %h required 0", {credit, dispense, dispense_item,
                               change_valid, change_amt, busy, insufficient, coin_reject});
        end
        @(negedge clk);
        rst_n = 1'b1;
        observe(6);
        n_checks++;
        if (obs_change !== 0 || obs_disp !== 0 || credit !== 10'd0) begin
            n_fail++; $display("FAIL midreset_after: change %0d disp %0d credit %0d required 0 0 0",
                               obs_change, obs_disp, credit);
        end
        m_credit = 0;
    endtask

    task automatic test_random();
        int kind, val, item, price, exp_change;
        for (int n = 0; n < 200; n++) begin
            kind = int'($urandom_range(99, 0));
            if (kind < 60) begin
                val = int'($urandom_range(3, 0));
                drive_coin(val);
                val = cents_of(val);
                observe(6);
                n_checks++;
                if (obs_reject !== ((m_credit + val > 500) ? 1 : 0)) begin
                    n_fail++; $display("FAIL rand_coin: rejects %0d credit_before %0d coin %0d", obs_reject, m_credit, val);
                end
                if (m_credit + val <= 500) m_credit += val;
            end else if (kind < 85) begin
                item  = int'($urandom_range(7, 0));
                price = price_of(item);
                drive_buy(item);
                observe(6);
                if (m_credit >= price) begin
                    exp_change = m_credit - price;
                    n_checks++;
                    if (obs_disp !== 1 || obs_item !== item || obs_insuf !== 0) begin
                        n_fail++; $display("FAIL rand_dispense: disp %0d item %0d required 1 item %0d", obs_disp, obs_item, item);
                    end
                    n_checks++;
                    if (obs_change !== ((exp_change > 0) ? 1 : 0) || (exp_change > 0 && obs_amt !== exp_change)) begin
                        n_fail++; $display("FAIL rand_change: count %0d amt %0d required amt %0d", obs_change, obs_amt, exp_change);
                    end
                    m_credit = 0;
                end else begin
                    n_checks++;
                    if (obs_insuf !== 1 || obs_disp !== 0 || obs_change !== 0) begin
                        n_fail++; $display("FAIL rand_insufficient: insuf %0d disp %0d change %0d required 1 0 0",
                                           obs_insuf, obs_disp, obs_change);
                    end
                end
            end else begin
                drive_cancel();
                observe(6);
                n_checks++;
                if (obs_change !== ((m_credit > 0) ? 1 : 0) || (m_credit > 0 && obs_amt !== m_credit)) begin
                    n_fail++; $display("FAIL rand_cancel: count %0d amt %0d required amt %0d", obs_change, obs_amt, m_credit);
                end
                m_credit = 0;
            end
            n_checks++;
            if (credit !== 10'(m_credit) || busy !== 1'b0) begin
                n_fail++; $display("FAIL rand_credit: credit %0d busy %b required %0d 0", credit, busy, m_credit);
            end
        end
    endtask

    initial begin
        test_reset();
        test_exact_buy();
        test_buy_with_change();
        test_insufficient();
        test_coin_reject();
        test_simultaneous();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
